dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the load/store requests issued by the MIPS pipeline's MEM stage. It accepts one request at a time over a valid/ready handshake and performs byte-enabled writes and word reads on an internal array. It returns a one-cycle response after a fixed, parameterised latency and drives `stall` so the pipeline holds MEM and the stages behind it until the response arrives. It replaces the combinational data memory for multi-cycle memory configurations.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; a power of two, 4..65536.
- `LATENCY`, default 2: cycles from the request cycle to the response cycle; 1..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present; held by the initiator until accepted.
- `req_ready`  out  1  responder idle and able to accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i enables `wdata[8i+7:8i]`.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load data; 0 for stores and for errors.
- `resp_err`  out  1  request was misaligned or out of range; qualified by `resp_valid`.
- `stall`  out  1  pipeline hold request.

## Operation
- The state machine has three states: IDLE, WAIT and RESP. The state encoding is shared.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` = 1 the request is accepted at the clock edge.
  - The next state is RESP if `LATENCY` = 1; otherwise it is WAIT, with the counter loaded to `LATENCY`-2.
- WAIT: the counter decrements each cycle; the state moves to RESP on the edge where the counter equals 0.
- RESP: `resp_valid` = 1 for exactly one cycle, then the state returns to IDLE. No request is accepted in RESP.
- Error condition: `req_addr[1:0]` ≠ 0, or word index `req_addr[31:2]` ≥ `DEPTH_WORDS`.
- On an error the memory is not modified, `resp_err` = 1 and `resp_rdata` = 0.
- Store:
  - Enabled bytes are committed to the array on the acceptance edge.
  - If `req_be` = 0, the array is unchanged and the store is still acknowledged with `resp_err` = 0.
  - `resp_rdata` = 0.
- Load:
  - The full word is captured into the response register on the acceptance edge.
  - `req_be` is ignored.
- Ordering: because only one request is outstanding, a load issued after a store to the same word returns the stored data.
- `stall` = (IDLE & `req_valid`) | WAIT. `stall` is 0 in RESP, so the MEM stage advances in the same cycle it sees `resp_valid`.
- Request inputs are sampled only on the acceptance edge. Later changes to them are ignored.

## Timing
- Reset values: state IDLE, counter 0, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `stall` = 0.
- Array contents are not reset.
- A request presented and accepted in cycle c produces `resp_valid` in cycle c+`LATENCY`.
- The earliest next acceptance is cycle c+`LATENCY`+1, giving a throughput of one request per `LATENCY`+1 cycles.
- `stall` is high from cycle c through cycle c+`LATENCY`-1 inclusive.
- With `LATENCY` = 1, WAIT is never entered.
- Reset asserted mid-operation (in WAIT or RESP):
  - The state returns to IDLE immediately and the pending response is dropped.
  - A store accepted before reset remains committed.
- If `req_valid` deasserts after acceptance, the transaction still completes.
- Address wrap: there is none. Out-of-range word indices report an error; they are not truncated.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (`DM_IDLE`, `DM_WAIT`, `DM_RESP`);
  - the word-index width function, `$clog2(DEPTH_WORDS)`;
  - the counter width, `$clog2(LATENCY)` with a minimum of 1.
- Sub-module `dmem_array`:
  - `DEPTH_WORDS` x 32 storage;
  - synchronous byte-enabled write;
  - synchronous read;
  - single port, since read and write never coincide.
- The top level contains the FSM, counter, error decode and response registers.

## Test plan
- Store then load with `LATENCY` = 2:
  - Store 0xDEADBEEF to 0x10 with be = 0xF, then load 0x10.
  - Required: the load response comes 2 cycles after request, `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `stall` high for 2 cycles per request.
- Byte enables:
  - Store 0x11223344 to 0x20 with be = 0xF, then store 0xAABBCCDD with be = 0x5.
  - Required: a load of 0x20 returns 0x11BB33DD.
- Error cases:
  - Load from 0x22 (misaligned), and store to word index `DEPTH_WORDS` (0x400 at the default depth).
  - Required: `resp_err` = 1, `resp_rdata` = 0, and a later load of 0x3FC is unchanged.
- Back-to-back requests with `LATENCY` = 1, `req_valid` held high for 3 loads:
  - Required: acceptances in cycles 0, 2 and 4; `resp_valid` in cycles 1, 3 and 5; `stall` = 1 exactly in cycles 0, 2 and 4.
- Reset mid-operation with `LATENCY` = 4:
  - Accept a store of 0x55 to 0x8, then assert `rst_n` = 0 during WAIT.
  - Required: no `resp_valid`; outputs return to reset values asynchronously; after release, a load of 0x8 returns 0x00000055.
- `LATENCY` = 16 with a zero-be store:
  - Required: the response arrives at cycle c+16 with `resp_err` = 0 and memory unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmState_t : responder state encoding (DM_IDLE, DM_WAIT, DM_RESP)
//   - idxWidth  : width of the word index for a given array depth
//   - cntWidth  : width of the latency counter for a given latency (min 1)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmState_t;

    // Word-index width for an array of depthWords 32-bit words.
    function automatic int idxWidth(input int depthWords);
        return $clog2(depthWords);
    endfunction

    // The counter only ever holds LATENCY-2, so $clog2(LATENCY) bits suffice;
    // a floor of one bit keeps the LATENCY = 1/2 cases legal.
    function automatic int cntWidth(input int latency);
        return ($clog2(latency) < 1) ? 1 : $clog2(latency);
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port DEPTH_WORDS x 32 storage with a byte-enabled synchronous write
// and a registered read. Read and write never happen in the same cycle, so
// one port serves both. Contents and the read register are not reset.
//
// Ports:
//   clk    in   clock
//   en     in   access strobe (one cycle per accepted, error-free request)
//   we     in   1 = write enabled bytes, 0 = read word into rdata
//   be     in   byte enables, bit i covers wdata[8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data, updated on the edge of a read access and held
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = idxWidth(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdataReg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdataReg <= mem[addr];
            end
        end
    end

    assign rdata = rdataReg;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory for the MEM stage. One request at a time is taken
// over a valid/ready handshake; the response strobe appears LATENCY cycles
// after acceptance, and stall holds the pipeline until then.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present (held until accepted)
//   req_ready   out  idle, request can be accepted
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_be      in   store byte enables
//   resp_valid  out  one-cycle response strobe
//   resp_rdata  out  load data (0 for stores and errors)
//   resp_err    out  misaligned / out-of-range request, qualified by resp_valid
//   stall       out  pipeline hold: (IDLE & req_valid) | WAIT
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int AW = idxWidth(DEPTH_WORDS);
    localparam int CW = cntWidth(LATENCY);

    // WAIT is entered with LATENCY-2 so that the exit edge (counter = 0)
    // lands the response exactly LATENCY cycles after acceptance.
    localparam int            LOAD_VAL = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_VAL);

    dmState_t      stateReg, stateNext;
    logic [CW-1:0] cntReg, cntNext;

    logic          errReg;       // accepted request was in error
    logic          loadReg;      // accepted request was a good load
    logic [31:0]   arrRdata;

    logic          accept;
    logic          misaligned;
    logic          outOfRange;
    logic          reqErr;
    logic [AW-1:0] wordIdx;

    assign accept     = (stateReg == DM_IDLE) && req_valid;
    assign misaligned = (req_addr[1:0] != 2'b00);
    // Any set bit above the index field means word index >= DEPTH_WORDS;
    // addresses never wrap into the array.
    assign outOfRange = |req_addr[31:AW+2];
    assign reqErr     = misaligned || outOfRange;
    assign wordIdx    = req_addr[AW+1:2];

    // Stores commit on the acceptance edge; loads capture into the array's
    // read register on the same edge, which then stays put until the next
    // access (no other access can occur before the response).
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) uArray (
        .clk   (clk),
        .en    (accept && !reqErr),
        .we    (req_write),
        .be    (req_be),
        .addr  (wordIdx),
        .wdata (req_wdata),
        .rdata (arrRdata)
    );

    // State, counter and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= DM_IDLE;
            cntReg   <= '0;
            errReg   <= 1'b0;
            loadReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                errReg  <= reqErr;
                loadReg <= !req_write && !reqErr;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            DM_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        stateNext = DM_RESP;
                    end else begin
                        stateNext = DM_WAIT;
                        cntNext   = CNT_LOAD;
                    end
                end
            end
            DM_WAIT: begin
                if (cntReg == '0) begin
                    stateNext = DM_RESP;
                end else begin
                    cntNext = cntReg - CW'(1);
                end
            end
            DM_RESP: begin
                stateNext = DM_IDLE;
            end
            default: begin
                stateNext = DM_IDLE;
            end
        endcase
    end

    // Outputs. Response data and error are gated by the strobe so they read
    // as zero whenever no response is being presented.
    always_comb begin
        req_ready  = (stateReg == DM_IDLE);
        resp_valid = (stateReg == DM_RESP);
        stall      = ((stateReg == DM_IDLE) && req_valid) || (stateReg == DM_WAIT);
        resp_err   = resp_valid && errReg;
        resp_rdata = (resp_valid && loadReg) ? arrRdata : 32'h0;
    end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Four responder instances (LATENCY 2, 1, 4, 16) share one clock. Stimulus
// pushes the expected response of every request into a scoreboard queue; a
// separate monitor pops and compares whenever any instance raises resp_valid.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI = 4;

    function automatic int latOf(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic [NI-1:0]   rstN;
    logic [NI-1:0]   reqValid;
    logic [NI-1:0]   reqReady;
    logic [NI-1:0]   reqWrite;
    logic [31:0]     reqAddr  [NI];
    logic [31:0]     reqWdata [NI];
    logic [3:0]      reqBe    [NI];
    logic [NI-1:0]   respValid;
    logic [31:0]     respRdata [NI];
    logic [NI-1:0]   respErr;
    logic [NI-1:0]   stall;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (256),
            .LATENCY     (latOf(gi))
        ) uDut (
            .clk        (clk),
            .rst_n      (rstN[gi]),
            .req_valid  (reqValid[gi]),
            .req_ready  (reqReady[gi]),
            .req_write  (reqWrite[gi]),
            .req_addr   (reqAddr[gi]),
            .req_wdata  (reqWdata[gi]),
            .req_be     (reqBe[gi]),
            .resp_valid (respValid[gi]),
            .resp_rdata (respRdata[gi]),
            .resp_err   (respErr[gi]),
            .stall      (stall[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (respValid[i] !== 1'b0) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_resp: inst %0d cycle %0d, no response expected", i, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("resp_inst c%0d", cyc), i, e.inst);
                    check($sformatf("resp_cycle inst%0d", i), cyc, e.cyc);
                    check($sformatf("resp_rdata inst%0d c%0d", i, cyc), respRdata[i], e.rdata);
                    check($sformatf("resp_err inst%0d c%0d", i, cyc), {31'b0, respErr[i]}, {31'b0, e.err});
                    $display("resp inst%0d cycle %0d rdata=0x%08h err=%0b", i, cyc, respRdata[i], respErr[i]);
                end
            end
        end
    end

    // One request on instance i; waits for its response and checks the
    // number of cycles stall was high.
    task automatic issue(input int i, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] expRdata, input bit expErr);
        int   n;
        int   stallCnt;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (reqReady[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (reqReady[i] !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: inst %0d never ready, got %0b required 1", i, reqReady[i]);
            return;
        end
        reqValid[i] = 1'b1;
        reqWrite[i] = wr;
        reqAddr[i]  = addr;
        reqWdata[i] = wdata;
        reqBe[i]    = be;
        #2;
        check($sformatf("stall_accept inst%0d", i), {31'b0, stall[i]}, 32'd1);
        e.inst  = i;
        e.rdata = expRdata;
        e.err   = expErr;
        e.cyc   = cyc + latOf(i);
        sb.push_back(e);
        $display("req  inst%0d cycle %0d %s addr=0x%08h wdata=0x%08h be=%h", i, cyc,
                 wr ? "ST" : "LD", addr, wdata, be);
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the responder must ignore it.
        reqValid[i] = 1'b0;
        reqWrite[i] = ~wr;
        reqAddr[i]  = ~addr;
        reqWdata[i] = ~wdata;
        reqBe[i]    = ~be;
        stallCnt = 1;
        n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (stall[i] === 1'b1) stallCnt++;
            if (respValid[i] === 1'b1) break;
            n++;
            if (n > 40) begin
                compared++;
                mismatched++;
                $display("FAIL resp_timeout: inst %0d no resp_valid, got 0 required 1", i);
                break;
            end
        end
        check($sformatf("stall_cycles inst%0d", i), stallCnt, latOf(i));
    endtask

    initial begin
        int             t0;
        logic [5:0]     stallBits;
        logic [5:0]     readyBits;
        logic [31:0]    b2bAddr [3];
        logic [31:0]    b2bData [3];
        exp_t           e;

        b2bAddr = '{32'h100, 32'h104, 32'h108};
        b2bData = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};

        rstN     = '0;
        reqValid = '0;
        reqWrite = '0;
        for (int i = 0; i < NI; i++) begin
            reqAddr[i]  = '0;
            reqWdata[i] = '0;
            reqBe[i]    = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready inst%0d", i), {31'b0, reqReady[i]}, 32'd1);
            check($sformatf("rst_resp_valid inst%0d", i), {31'b0, respValid[i]}, 32'd0);
            check($sformatf("rst_rdata inst%0d", i), respRdata[i], 32'd0);
            check($sformatf("rst_err inst%0d", i), {31'b0, respErr[i]}, 32'd0);
            check($sformatf("rst_stall inst%0d", i), {31'b0, stall[i]}, 32'd0);
        end
        rstN = '1;

        // LATENCY 2: store/load, byte enables, error cases.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0);
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0);
        issue(0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0);
        issue(0, 1, 32'h0, 32'h01020304, 4'hF, 32'h0, 0);
        issue(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 0);
        issue(0, 0, 32'h22, 32'h0, 4'hF, 32'h0, 1);
        issue(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        issue(0, 1, 32'h3FE, 32'h77777777, 4'hF, 32'h0, 1);
        issue(0, 0, 32'h8000_0000, 32'h0, 4'hF, 32'h0, 1);
        issue(0, 0, 32'h3FC, 32'h0, 4'hF, 32'hCAFEF00D, 0);
        issue(0, 0, 32'h0, 32'h0, 4'hF, 32'h01020304, 0);

        // LATENCY 1: fill three words, then back-to-back loads with valid held.
        for (int k = 0; k < 3; k++) issue(1, 1, b2bAddr[k], b2bData[k], 4'hF, 32'h0, 0);
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWrite[1] = 1'b0;
        reqAddr[1]  = b2bAddr[0];
        reqBe[1]    = 4'hF;
        t0 = cyc;
        for (int j = 0; j < 6; j++) begin
            #2;
            stallBits[j] = stall[1];
            readyBits[j] = reqReady[1];
            if (j % 2 == 0) begin
                e.inst  = 1;
                e.rdata = b2bData[j/2];
                e.err   = 1'b0;
                e.cyc   = cyc + 1;
                sb.push_back(e);
                $display("req  inst1 cycle %0d LD addr=0x%08h (back-to-back)", cyc - t0, reqAddr[1]);
            end else if (j < 5) begin
                reqAddr[1] = b2bAddr[(j+1)/2];
            end else begin
                reqValid[1] = 1'b0;
            end
            if (j < 5) @(negedge clk);
        end
        check("b2b_stall_pattern", {26'b0, stallBits}, 32'b010101);
        check("b2b_ready_pattern", {26'b0, readyBits}, 32'b010101);

        // LATENCY 4: reset during WAIT drops the response, keeps the store.
        @(negedge clk);
        reqValid[2] = 1'b1;
        reqWrite[2] = 1'b1;
        reqAddr[2]  = 32'h8;
        reqWdata[2] = 32'h55;
        reqBe[2]    = 4'hF;
        @(posedge clk);
        #1;
        reqValid[2] = 1'b0;
        $display("req  inst2 cycle %0d ST addr=0x00000008 wdata=0x00000055 (reset follows)", cyc - 1);
        @(negedge clk);
        #2;
        check("wait_stall inst2", {31'b0, stall[2]}, 32'd1);
        check("wait_ready inst2", {31'b0, reqReady[2]}, 32'd0);
        @(negedge clk);
        #2;
        rstN[2] = 1'b0;
        #1;
        check("async_rst_ready inst2", {31'b0, reqReady[2]}, 32'd1);
        check("async_rst_stall inst2", {31'b0, stall[2]}, 32'd0);
        check("async_rst_valid inst2", {31'b0, respValid[2]}, 32'd0);
        check("async_rst_rdata inst2", respRdata[2], 32'd0);
        check("async_rst_err inst2", {31'b0, respErr[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rstN[2] = 1'b1;
        repeat (8) @(negedge clk);
        issue(2, 0, 32'h8, 32'h0, 4'hF, 32'h00000055, 0);

        // LATENCY 16: zero-byte-enable store is acknowledged and changes nothing.
        issue(3, 1, 32'h40, 32'h12345678, 4'hF, 32'h0, 0);
        issue(3, 1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        issue(3, 0, 32'h40, 32'h0, 4'hF, 32'h12345678, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_responder
